// File: rtl/spi_tx_engine.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmit engine: pops a first-word-fall-through TX FIFO
// and serialises words on mosi/sclk/cs_n. Define SPI_TX_LSB_EN to add the lsb_first input.
module spi_tx_engine #(
  parameter int SizeWord = 8,
  parameter int ClkDiv   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                abort,
  input  logic                fifo_empty,
  input  logic [SizeWord-1:0] fifo_rdata,
`ifdef SPI_TX_LSB_EN
  input  logic                lsb_first,
`endif
  output logic                fifo_ren,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic                busy,
  output logic                done
);

  localparam int DW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BW = (SizeWord > 1) ? $clog2(SizeWord) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

  state_t              state, state_nxt;
  logic [SizeWord-1:0] shreg;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bitcnt;
  logic                lsb_q;
  logic                lsb_in;
  logic                div_end, word_end, load_req;
  logic                first_bit, nxt_bit;

`ifdef SPI_TX_LSB_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign div_end   = (div_cnt == DW'(ClkDiv - 1));
  // Final falling sclk edge of the word: the reload/trail decision point.
  assign word_end  = (state == SHIFT) && div_end && sclk && (bitcnt == BW'(SizeWord - 1));
  assign load_req  = enable && !fifo_empty;
  assign first_bit = lsb_in ? fifo_rdata[0] : fifo_rdata[SizeWord-1];
  assign nxt_bit   = lsb_q ? shreg[1] : shreg[SizeWord-2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    if (load_req) state_nxt = SHIFT;
        SHIFT:   if (word_end) state_nxt = load_req ? SHIFT : TRAIL;
        TRAIL:   if (div_end) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: pop and done are combinational so the next pop lands on the done cycle.
  always_comb begin
    fifo_ren = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    if (!rst && !abort) begin
      fifo_ren = load_req && ((state == IDLE) || word_end);
      done     = word_end;
    end
  end

  // Datapath and pin registers
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_ren) begin
            shreg   <= fifo_rdata;
            mosi    <= first_bit;
            lsb_q   <= lsb_in;
            cs_n    <= 1'b0;
            div_cnt <= '0;
            bitcnt  <= '0;
          end
        end
        SHIFT: begin
          if (!div_end) div_cnt <= div_cnt + 1'b1;
          else begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
              if (bitcnt != BW'(SizeWord - 1)) begin
                shreg  <= lsb_q ? {1'b0, shreg[SizeWord-1:1]} : {shreg[SizeWord-2:0], 1'b0};
                mosi   <= nxt_bit;
                bitcnt <= bitcnt + 1'b1;
              end else if (fifo_ren) begin
                shreg  <= fifo_rdata;
                mosi   <= first_bit;
                lsb_q  <= lsb_in;
                bitcnt <= '0;
              end else begin
                mosi   <= 1'b0;
              end
            end
          end
        end
        TRAIL: begin
          if (div_end) begin
            cs_n    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// Bench for spi_tx_engine: queue-based FIFO model, pin monitor, and a bit-stream/timing
// reference derived from the word contents and the sclk divider arithmetic.
module tb_spi_tx_engine;
  localparam int SW = 8;
  localparam int CD = 4;
  localparam int WORD_CYC = 2 * CD * SW;

  logic          clk = 1'b0;
  logic          rst, enable, abort, lsb_first_r;
  logic          fifo_empty = 1'b1;
  logic [SW-1:0] fifo_rdata = '0;
  logic          fifo_ren, sclk, mosi, cs_n, busy, done;

  spi_tx_engine #(.SizeWord(SW), .ClkDiv(CD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
`ifdef SPI_TX_LSB_EN
    .lsb_first(lsb_first_r),
`endif
    .fifo_ren(fifo_ren), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [SW-1:0] fq[$];
  logic [SW-1:0] words_q[$];
  int rise_q[$], done_q[$], ren_q[$], cs_q[$];
  bit bit_q[$];
  int sclk_hi, busy_hi, viol;
  bit pop_pend = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pops one cycle after a fifo_ren is seen, head word falls through
  always @(posedge clk) begin
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    pop_pend = 0;
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? SW'($urandom) : fq[0];
  end

  // Pin monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rise_q.push_back(cyc);
      bit_q.push_back(mosi);
    end
    sclk_prev = sclk;
    if (done === 1'b1) done_q.push_back(cyc);
    if (fifo_ren === 1'b1) begin
      ren_q.push_back(cyc);
      pop_pend = 1;
      if (fifo_empty) viol++;
    end
    if (cs_n === 1'b1 && cs_prev === 1'b0) cs_q.push_back(cyc);
    cs_prev = cs_n;
    if (sclk === 1'b1) sclk_hi++;
    if (busy === 1'b1) busy_hi++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    rise_q.delete(); bit_q.delete(); done_q.delete(); ren_q.delete(); cs_q.delete();
    sclk_hi = 0; busy_hi = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int q0(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Sends words_q as one burst and checks bit stream and timing against the model
  task automatic do_burst(input string tag, input bit lsb);
    int n, b, exp_v, cap, chain;
    n = words_q.size();
    foreach (words_q[i]) fq.push_back(words_q[i]);
    step();
    clear_mon();
    lsb_first_r = lsb;
    enable = 1;
    b = 0;
    while (done_q.size() < n && b < WORD_CYC * n + 100) begin step(); b++; end
    enable = 0;
    b = 0;
    while (!(cs_n === 1'b1 && busy === 1'b0) && b < 50) begin step(); b++; end
    step();
    exp_v = 0;
    foreach (words_q[i])
      for (int k = 0; k < SW; k++) begin
        logic [SW-1:0] w;
        w = words_q[i];
        exp_v = (exp_v << 1) | int'(lsb ? w[k] : w[SW-1-k]);
      end
    cap = 0;
    foreach (bit_q[i]) cap = (cap << 1) | int'(bit_q[i]);
    chain = 0;
    for (int j = 1; j < n; j++) if (q0(ren_q, j) != q0(done_q, j - 1)) chain++;
    chk({tag, "/nbits"}, bit_q.size(), SW * n);
    chk({tag, "/bits"}, cap, exp_v);
    chk({tag, "/ren_cnt"}, ren_q.size(), n);
    chk({tag, "/done_cnt"}, done_q.size(), n);
    chk({tag, "/cs_rises"}, cs_q.size(), 1);
    chk({tag, "/first_rise"}, q0(rise_q, 0), q0(ren_q, 0) + 1 + CD);
    chk({tag, "/last_done"}, q0(done_q, n - 1), q0(ren_q, 0) + WORD_CYC * n);
    chk({tag, "/cs_rise_t"}, q0(cs_q, 0), q0(done_q, n - 1) + 1 + CD);
    chk({tag, "/ren_chain"}, chain, 0);
    words_q.delete();
  endtask

  initial begin
    int b, n;
    rst = 1; enable = 0; abort = 0; lsb_first_r = 0;
    fq.push_back(8'hA5);
    repeat (3) step();
    enable = 1;
    step();
    chk("rst/cs_n", int'(cs_n), 1);
    chk("rst/sclk", int'(sclk), 0);
    chk("rst/mosi", int'(mosi), 0);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/fifo_ren", int'(fifo_ren), 0);
    enable = 0; rst = 0;

    // enable low with FIFO non-empty: nothing moves
    step();
    clear_mon();
    repeat (100) step();
    chk("idle/ren", ren_q.size(), 0);
    chk("idle/sclk", sclk_hi, 0);
    chk("idle/busy", busy_hi, 0);
    fq.delete();
    step();

    words_q = '{8'hA5};
    do_burst("a5", 0);
    words_q = '{8'h3C, 8'hFF};
    do_burst("3c_ff", 0);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) words_q.push_back(SW'($urandom));
      do_burst($sformatf("rnd%0d", r), 0);
    end

    // abort after the 3rd rise
    fq.push_back(8'hA5);
    step();
    clear_mon();
    enable = 1;
    b = 0;
    while (rise_q.size() < 3 && b < 200) begin step(); b++; end
    chk("abort/rises_before", rise_q.size(), 3);
    abort = 1;
    step();
    abort = 0;
    chk("abort/cs_n", int'(cs_n), 1);
    chk("abort/sclk", int'(sclk), 0);
    chk("abort/mosi", int'(mosi), 0);
    chk("abort/busy", int'(busy), 0);
    repeat (80) step();
    chk("abort/done_cnt", done_q.size(), 0);
    chk("abort/ren_cnt", ren_q.size(), 1);
    enable = 0;

    // reset mid-word with another word waiting
    fq.push_back(SW'($urandom));
    fq.push_back(8'h5A);
    step();
    clear_mon();
    enable = 1;
    b = 0;
    while (rise_q.size() < 2 && b < 200) begin step(); b++; end
    rst = 1;
    step();
    chk("rstmid/cs_n", int'(cs_n), 1);
    chk("rstmid/sclk", int'(sclk), 0);
    chk("rstmid/mosi", int'(mosi), 0);
    chk("rstmid/busy", int'(busy), 0);
    chk("rstmid/fifo_ren", int'(fifo_ren), 0);
    enable = 0;
    step();
    rst = 0;
    repeat (80) step();
    chk("rstmid/done_cnt", done_q.size(), 0);
    chk("rstmid/ren_cnt", ren_q.size(), 1);
    fq.delete();
    step();

`ifdef SPI_TX_LSB_EN
    words_q = '{8'h01};
    do_burst("lsb01", 1);
    words_q = '{SW'($urandom), SW'($urandom)};
    do_burst("lsb_rnd", 1);
`endif

    chk("ren_while_empty", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
